// File: rtl/stack_pkg.sv
// Shared constants for the 4-bit stack datapath: stack_register modes,
// sequencer opcodes and sequencer state encodings.
package stack_pkg;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] STACK_MODE_IDLE  = 3'd0;
  localparam logic [MODE_W-1:0] STACK_MODE_RESET = 3'd1;
  localparam logic [MODE_W-1:0] STACK_MODE_PUSH  = 3'd2;
  localparam logic [MODE_W-1:0] STACK_MODE_POP   = 3'd3;
  localparam logic [MODE_W-1:0] STACK_MODE_SWAP  = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_OUTH = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5;
  localparam logic [3:0] OP_PEEK = 4'h6;
  localparam logic [3:0] OP_DUP  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_ADD  = 4'hB;
  localparam logic [3:0] OP_SUB  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_INC  = 4'hE;
  localparam logic [3:0] OP_CLR  = 4'hF;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_S1   = 2'd1,
    SEQ_S2   = 2'd2,
    SEQ_S3   = 2'd3
  } seq_state_e;

  // Shape of the micro-sequence following an accepted opcode.
  typedef enum logic [1:0] {
    KIND_SINGLE = 2'd0,
    KIND_UNARY  = 2'd1,
    KIND_BINARY = 2'd2
  } seq_kind_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational 4-bit ALU: v1 op v0 for binary ops, op v0 for unary ops.
module stack_alu
  import stack_pkg::*;
(
  input  logic [3:0] v0,
  input  logic [3:0] v1,
  input  logic [3:0] op,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero
);

  logic [4:0] wide;

  always_comb begin
    wide  = '0;
    carry = 1'b0;
    case (op)
      OP_AND: wide = {1'b0, v1 & v0};
      OP_OR:  wide = {1'b0, v1 | v0};
      OP_XOR: wide = {1'b0, v1 ^ v0};
      OP_ADD: begin
        wide  = {1'b0, v1} + {1'b0, v0};
        carry = wide[4];
      end
      OP_SUB: begin
        wide  = {1'b0, v1} - {1'b0, v0};
        carry = (v1 < v0);
      end
      OP_NOT: wide = {1'b0, ~v0};
      OP_INC: begin
        wide  = {1'b0, v0} + 5'd1;
        carry = wide[4];
      end
      default: wide = '0;
    endcase
    result = wide[3:0];
    zero   = (wide[3:0] == 4'd0);
  end

endmodule

// File: rtl/stack_sequencer.sv
// Opcode sequencer for the 4-bit stack: expands opcodes into stack_register
// micro-ops, tracks depth, owns the output latch and the ALU flags.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_valid,
  input  logic [3:0]                   op_code,
  input  logic [3:0]                   op_imm,
  output logic                         op_ready,
  input  logic [3:0]                   top_word,
  input  logic [3:0]                   second_word,
  output logic [2:0]                   stack_mode,
  output logic [3:0]                   push_word,
  output logic [7:0]                   out_byte,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         carry,
  output logic                         zero,
  output logic                         err
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  seq_state_e          state_q, state_d;
  seq_kind_e           kind_q, kind_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                op_ready_q, op_ready_d;
  logic [WORD_W-1:0]   push_word_q, push_word_d;
  logic [WORD_W-1:0]   res_q, res_d;
  logic [7:0]          out_byte_q, out_byte_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic [3:0] alu_res;
  logic       alu_carry;
  logic       alu_zero;
  logic       has1, has2, room;

  stack_alu u_alu (
    .v0     (top_word),
    .v1     (second_word),
    .op     (op_code),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign has1 = (depth_q != '0);
  assign has2 = (depth_q >= DEPTH_W'(2));
  assign room = (depth_q < DEPTH_W'(DEPTH));

  // Next-state, micro-op issue and bookkeeping.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    mode_d      = STACK_MODE_IDLE;
    push_word_d = push_word_q;
    res_d       = res_q;
    out_byte_d  = out_byte_q;
    depth_d     = depth_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;

    case (state_q)
      SEQ_IDLE: begin
        if (op_valid && op_ready_q) begin
          kind_d = KIND_SINGLE;
          case (op_code)
            OP_NOP: ;
            OP_PUSH, OP_PEEK, OP_DUP: begin
              if (room && ((op_code == OP_PUSH) ||
                           (op_code == OP_PEEK && has2) ||
                           (op_code == OP_DUP && has1))) begin
                mode_d      = STACK_MODE_PUSH;
                push_word_d = (op_code == OP_PUSH) ? op_imm :
                              (op_code == OP_PEEK) ? second_word : top_word;
                depth_d     = depth_q + DEPTH_W'(1);
                state_d     = SEQ_S1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_POP: begin
              if (has1) begin
                mode_d  = STACK_MODE_POP;
                depth_d = depth_q - DEPTH_W'(1);
                state_d = SEQ_S1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_OUTL, OP_OUTH: begin
              if (!has1)                err_d = 1'b1;
              else if (op_code == OP_OUTL) out_byte_d[3:0] = top_word;
              else                      out_byte_d[7:4] = top_word;
            end
            OP_SWAP: begin
              if (has2) begin
                mode_d  = STACK_MODE_SWAP;
                state_d = SEQ_S1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: begin
              if (has2) begin
                mode_d  = STACK_MODE_POP;
                kind_d  = KIND_BINARY;
                res_d   = alu_res;
                carry_d = alu_carry;
                zero_d  = alu_zero;
                depth_d = depth_q - DEPTH_W'(1);
                state_d = SEQ_S1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_NOT, OP_INC: begin
              if (has1) begin
                mode_d  = STACK_MODE_POP;
                kind_d  = KIND_UNARY;
                res_d   = alu_res;
                carry_d = alu_carry;
                zero_d  = alu_zero;
                state_d = SEQ_S1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLR: begin
              mode_d  = STACK_MODE_RESET;
              depth_d = '0;
              carry_d = 1'b0;
              zero_d  = 1'b0;
              err_d   = 1'b0;
              state_d = SEQ_S1;
            end
            default: ;
          endcase
        end
      end
      SEQ_S1: begin
        case (kind_q)
          KIND_BINARY: begin
            mode_d  = STACK_MODE_POP;
            state_d = SEQ_S2;
          end
          KIND_UNARY: begin
            mode_d      = STACK_MODE_PUSH;
            push_word_d = res_q;
            state_d     = SEQ_S3;
          end
          default: state_d = SEQ_IDLE;
        endcase
      end
      SEQ_S2: begin
        mode_d      = STACK_MODE_PUSH;
        push_word_d = res_q;
        state_d     = SEQ_S3;
      end
      SEQ_S3: state_d = SEQ_IDLE;
      default: state_d = SEQ_IDLE;
    endcase

    op_ready_d = (state_d == SEQ_IDLE);
  end

  // Reset holds stack_register in RESET mode and blocks acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      kind_q      <= KIND_SINGLE;
      mode_q      <= STACK_MODE_RESET;
      op_ready_q  <= 1'b0;
      push_word_q <= '0;
      res_q       <= '0;
      out_byte_q  <= '0;
      depth_q     <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      mode_q      <= mode_d;
      op_ready_q  <= op_ready_d;
      push_word_q <= push_word_d;
      res_q       <= res_d;
      out_byte_q  <= out_byte_d;
      depth_q     <= depth_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign op_ready   = op_ready_q;
  assign stack_mode = mode_q;
  assign push_word  = push_word_q;
  assign out_byte   = out_byte_q;
  assign depth      = depth_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign err        = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural stand-in for
// stack_register closing the top_word/second_word loop.
module tb_stack_sequencer;
  import stack_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [3:0] op_code = 4'h0;
  logic [3:0] op_imm = 4'h0;
  logic       op_ready;
  logic [3:0] top_word, second_word;
  logic [2:0] stack_mode;
  logic [3:0] push_word;
  logic [7:0] out_byte;
  logic [3:0] depth;
  logic       carry, zero, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy, last_acc, acc_a;

  always #5 clk = ~clk;

  stack_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_imm     (op_imm),
    .op_ready   (op_ready),
    .top_word   (top_word),
    .second_word(second_word),
    .stack_mode (stack_mode),
    .push_word  (push_word),
    .out_byte   (out_byte),
    .depth      (depth),
    .carry      (carry),
    .zero       (zero),
    .err        (err)
  );

  // Stand-in stack_register: applies stack_mode at each rising edge.
  logic [3:0] stk [DEPTH];
  int stk_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (stack_mode)
      STACK_MODE_RESET: begin
        for (int i = 0; i < int'(DEPTH); i++) stk[i] <= 4'h0;
        stk_cnt <= 0;
      end
      STACK_MODE_PUSH: begin
        for (int i = int'(DEPTH) - 1; i > 0; i--) stk[i] <= stk[i-1];
        stk[0]  <= push_word;
        stk_cnt <= stk_cnt + 1;
      end
      STACK_MODE_POP: begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) stk[i] <= stk[i+1];
        stk[DEPTH-1] <= 4'h0;
        stk_cnt <= stk_cnt - 1;
      end
      STACK_MODE_SWAP: begin
        stk[0] <= stk[1];
        stk[1] <= stk[0];
      end
      default: ;
    endcase
  end
  assign top_word    = stk[0];
  assign second_word = stk[1];

  // Log of issued micro-ops and pushed words.
  logic [2:0] mq[$];
  logic [3:0] pq[$];
  always @(negedge clk) begin
    if (rst_n && stack_mode !== STACK_MODE_IDLE) begin
      mq.push_back(stack_mode);
      if (stack_mode === STACK_MODE_PUSH) pq.push_back(push_word);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_modes(input string tag, input int n, input logic [14:0] exp);
    logic [14:0] v;
    v = '0;
    for (int i = 0; i < mq.size(); i++) v = {v[11:0], mq[i]};
    check({tag, "_count"}, 32'(mq.size()), 32'(n));
    check({tag, "_seq"}, 32'(v), 32'(exp));
    mq.delete();
  endtask

  function automatic logic [3:0] last_push();
    if (pq.size() == 0) return 4'hX;
    return pq[pq.size()-1];
  endfunction

  // Present one opcode, wait for acceptance, then count busy cycles.
  task automatic send(input logic [3:0] code, input logic [3:0] imm);
    int n;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    op_imm   = imm;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("accept_timeout", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    last_acc = cyc;
    busy = 0;
    while (!op_ready && busy < 10) begin
      @(posedge clk);
      #1;
      busy++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mode", 32'(stack_mode), 32'(STACK_MODE_RESET));
    check("rst_ready", 32'(op_ready), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_outs", {push_word, out_byte, carry, zero, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(op_ready), 32'd1);
    check("rel_mode", 32'(stack_mode), 32'(STACK_MODE_IDLE));
    mq.delete();
    pq.delete();

    // PUSH 3, PUSH 5, ADD
    send(OP_PUSH, 4'h3);
    check("push_busy", 32'(busy), 32'd1);
    send(OP_PUSH, 4'h5);
    send(OP_ADD, 4'h0);
    check("add_busy", 32'(busy), 32'd3);
    check_modes("add", 5, {STACK_MODE_PUSH, STACK_MODE_PUSH, STACK_MODE_POP,
                           STACK_MODE_POP, STACK_MODE_PUSH});
    check("add_word", 32'(last_push()), 32'h8);
    check("add_depth", 32'(depth), 32'd1);
    check("add_flags", {carry, zero}, 32'd0);
    check("add_top", 32'(top_word), 32'h8);

    // Carry / borrow / zero flags
    send(OP_CLR, 4'h0);
    check("clr_busy", 32'(busy), 32'd1);
    check_modes("clr", 1, 15'(STACK_MODE_RESET));
    check("clr_depth", 32'(depth), 32'd0);
    send(OP_PUSH, 4'h9);
    send(OP_PUSH, 4'h8);
    send(OP_ADD, 4'h0);
    check("add2_word", 32'(last_push()), 32'h1);
    check("add2_cz", {carry, zero}, 32'b10);
    send(OP_PUSH, 4'h1);
    send(OP_SUB, 4'h0);
    check("sub0_word", 32'(last_push()), 32'h0);
    check("sub0_cz", {carry, zero}, 32'b01);
    send(OP_PUSH, 4'h1);
    send(OP_SUB, 4'h0);
    check("subf_word", 32'(last_push()), 32'hF);
    check("subf_cz", {carry, zero}, 32'b10);
    check("subf_depth", 32'(depth), 32'd1);

    // Underflow, then CLR clears err
    send(OP_CLR, 4'h0);
    mq.delete();
    send(OP_POP, 4'h0);
    check("uf_busy", 32'(busy), 32'd0);
    check("uf_ready", 32'(op_ready), 32'd1);
    check("uf_err", 32'(err), 32'd1);
    check("uf_depth", 32'(depth), 32'd0);
    check_modes("uf", 0, 15'd0);
    send(OP_CLR, 4'h0);
    check("clr_err", 32'(err), 32'd0);
    check_modes("clr2", 1, 15'(STACK_MODE_RESET));

    // Overflow
    for (int k = 0; k < int'(DEPTH); k++) send(OP_PUSH, 4'hA);
    check("full_depth", 32'(depth), 32'd8);
    check("full_err", 32'(err), 32'd0);
    mq.delete();
    send(OP_DUP, 4'h0);
    check("of_busy", 32'(busy), 32'd0);
    check("of_err", 32'(err), 32'd1);
    check("of_depth", 32'(depth), 32'd8);
    check_modes("of", 0, 15'd0);
    send(OP_CLR, 4'h0);
    mq.delete();

    // Output latch
    send(OP_PUSH, 4'h7);
    send(OP_OUTL, 4'h0);
    check("outl_busy", 32'(busy), 32'd0);
    send(OP_PUSH, 4'hC);
    send(OP_OUTH, 4'h0);
    check("outh_busy", 32'(busy), 32'd0);
    check("out_c7", 32'(out_byte), 32'hC7);
    send(OP_OUTL, 4'h0);
    acc_a = last_acc;
    check("b2b_busy1", 32'(busy), 32'd0);
    send(OP_OUTH, 4'h0);
    check("b2b_busy2", 32'(busy), 32'd0);
    check("b2b_gap", 32'(last_acc - acc_a), 32'd1);
    check("out_cc", 32'(out_byte), 32'hCC);

    // Reset during S2 of AND
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_AND;
    check("and_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("and_s1", 32'(stack_mode), 32'(STACK_MODE_POP));
    @(posedge clk);
    #1;
    check("and_s2", {op_ready, 1'b0, stack_mode}, {1'b0, 1'b0, STACK_MODE_POP});
    check("and_s2_depth", 32'(depth), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mode", 32'(stack_mode), 32'(STACK_MODE_RESET));
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel2_ready", 32'(op_ready), 32'd1);
    check("rel2_mode", 32'(stack_mode), 32'(STACK_MODE_IDLE));
    check("rel2_stack", 32'(stk_cnt), 32'd0);
    mq.delete();
    pq.delete();

    // Unary ops
    send(OP_PUSH, 4'hF);
    send(OP_INC, 4'h0);
    check("inc_busy", 32'(busy), 32'd2);
    check_modes("inc", 3, {6'd0, STACK_MODE_PUSH, STACK_MODE_POP, STACK_MODE_PUSH});
    check("inc_word", 32'(last_push()), 32'h0);
    check("inc_cz", {carry, zero}, 32'b11);
    check("inc_depth", 32'(depth), 32'd1);
    send(OP_NOT, 4'h0);
    check("not_word", 32'(last_push()), 32'hF);
    check("not_cz", {carry, zero}, 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
